framebuffer_access_scheduler: RTL and testbench

//   Owns the single memory port of the display framebuffer (memory: we/rdaddr/wraddr/wrdata/rddata)
//   and shares it between the pixel writer (read-modify-write of one word per plotted sample)
//   and an internal clear engine that zeroes the whole framebuffer at each frame start.

---
 rtl/framebuffer_access_scheduler.sv | 114 +++++++++++
 tb/tb_framebuffer_access_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_access_scheduler.sv
// Arbitrates the framebuffer memory port between the pixel writer's read-modify-write
// and a clear engine that zeroes NUM_WORDS words at each frame start.
module framebuffer_access_scheduler #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_LENGTH = 14,
    parameter int unsigned NUM_WORDS      = 9600
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      frame_start,
    input  logic                      px_req,
    output logic                      px_gnt,
    input  logic [ADDRESS_LENGTH-1:0] px_addr,
    input  logic                      px_we,
    input  logic [DATA_WIDTH-1:0]     px_wrdata,
    output logic [DATA_WIDTH-1:0]     px_rddata,
    output logic                      mem_we,
    output logic [ADDRESS_LENGTH-1:0] mem_rdaddr,
    output logic [ADDRESS_LENGTH-1:0] mem_wraddr,
    output logic [DATA_WIDTH-1:0]     mem_wrdata,
    input  logic [DATA_WIDTH-1:0]     mem_rddata,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      clear_overrun
);

    typedef enum logic [1:0] {StIdle, StPixel, StClear} state_e;

    localparam logic [ADDRESS_LENGTH-1:0] LastWord = ADDRESS_LENGTH'(NUM_WORDS - 1);

    state_e                    state_q, state_d;
    logic [ADDRESS_LENGTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                      clear_pending_q, clear_pending_d;
    logic                      clear_done_q, clear_done_d;
    logic                      clear_overrun_q, clear_overrun_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= StIdle;
            clr_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
            clear_done_q    <= 1'b0;
            clear_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            clear_pending_q <= clear_pending_d;
            clear_done_q    <= clear_done_d;
            clear_overrun_q <= clear_overrun_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clr_cnt_d       = clr_cnt_q;
        clear_pending_d = clear_pending_q;
        clear_done_d    = 1'b0;
        // A frame start during a clear, including its last cycle, never restarts it.
        clear_overrun_d = clear_overrun_q | (frame_start && (state_q == StClear));
        case (state_q)
            StIdle: begin
                if (clear_pending_q || frame_start) begin
                    state_d         = StClear;
                    clear_pending_d = 1'b0;
                end else if (px_req) begin
                    state_d = StPixel;
                end
            end
            StPixel: begin
                if (frame_start) clear_pending_d = 1'b1;
                if (!px_req) state_d = StIdle;
            end
            StClear: begin
                if (clr_cnt_q == LastWord) begin
                    clr_cnt_d    = '0;
                    state_d      = StIdle;
                    clear_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDRESS_LENGTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        px_gnt        = 1'b0;
        clear_busy    = 1'b0;
        mem_we        = 1'b0;
        mem_rdaddr    = '0;
        mem_wraddr    = '0;
        mem_wrdata    = '0;
        clear_done    = clear_done_q;
        clear_overrun = clear_overrun_q;
        px_rddata     = mem_rddata;
        case (state_q)
            StPixel: begin
                px_gnt     = 1'b1;
                mem_we     = px_we;
                mem_rdaddr = px_addr;
                mem_wraddr = px_addr;
                mem_wrdata = px_wrdata;
            end
            StClear: begin
                clear_busy = 1'b1;
                mem_we     = 1'b1;
                mem_rdaddr = clr_cnt_q;
                mem_wraddr = clr_cnt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_framebuffer_access_scheduler.sv
// Scoreboard bench: expected memory writes are queued by the stimulus and checked by a
// monitor; a behavioural framebuffer model supplies expected read and write data.
module tb_framebuffer_access_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 14;
    localparam int unsigned NW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          frame_start;
    logic          px_req;
    logic          px_gnt;
    logic [AW-1:0] px_addr;
    logic          px_we;
    logic [DW-1:0] px_wrdata;
    logic [DW-1:0] px_rddata;
    logic          mem_we;
    logic [AW-1:0] mem_rdaddr;
    logic [AW-1:0] mem_wraddr;
    logic [DW-1:0] mem_wrdata;
    logic [DW-1:0] mem_rddata;
    logic          clear_busy;
    logic          clear_done;
    logic          clear_overrun;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            prev_busy = 1'b0;
    int            run_len   = 0;

    framebuffer_access_scheduler #(
        .DATA_WIDTH    (DW),
        .ADDRESS_LENGTH(AW),
        .NUM_WORDS     (NW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .frame_start  (frame_start),
        .px_req       (px_req),
        .px_gnt       (px_gnt),
        .px_addr      (px_addr),
        .px_we        (px_we),
        .px_wrdata    (px_wrdata),
        .px_rddata    (px_rddata),
        .mem_we       (mem_we),
        .mem_rdaddr   (mem_rdaddr),
        .mem_wraddr   (mem_wraddr),
        .mem_wrdata   (mem_wrdata),
        .mem_rddata   (mem_rddata),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_wraddr] <= mem_wrdata;
        mem_rddata <= mem[mem_rdaddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: every memory write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (!resetn) begin
            prev_busy = 1'b0;
            run_len   = 0;
        end else begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    fail($sformatf("unexpected write addr 0x%0h data 0x%0h", mem_wraddr,
                                   mem_wrdata));
                end else begin
                    e = exp_q.pop_front();
                    check("write addr", 64'(mem_wraddr), 64'(e.addr));
                    check("write data", 64'(mem_wrdata), 64'(e.data));
                    check("read addr tracks write addr", 64'(mem_rdaddr), 64'(e.addr));
                end
            end
            if (px_gnt || clear_busy) check("gnt/busy exclusive", 64'(px_gnt & clear_busy), 0);
            if (clear_busy) run_len++;
            if (prev_busy && !clear_busy) begin
                check("clear_done after clear", 64'(clear_done), 1);
                check("clear length", 64'(run_len), 64'(NW));
                run_len = 0;
            end else if (clear_done) begin
                fail("spurious clear_done");
            end
            prev_busy = clear_busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back('{addr: AW'(i), data: '0});
            ref_mem[i] = '0;
        end
    endtask

    // Pulses frame_start in IDLE; returns during clear cycle 0.
    task automatic start_clear();
        frame_start = 1'b1;
        push_clear();
        step();
        frame_start = 1'b0;
        check("clear_busy on first clear cycle", 64'(clear_busy), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            step();
            n++;
        end while (!clear_done && n < 200);
        if (!clear_done) fail("clear_done timeout");
    endtask

    task automatic rmw(input logic [AW-1:0] addr, input logic [DW-1:0] mask, input bit fs);
        int n = 0;
        px_req  = 1'b1;
        px_addr = addr;
        px_we   = 1'b0;
        do begin
            step();
            n++;
        end while (!px_gnt && n < 200);
        if (!px_gnt) begin
            fail("grant timeout");
            px_req = 1'b0;
            return;
        end
        if (fs) frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("rmw read data", 64'(px_rddata), 64'(ref_mem[addr]));
        exp_q.push_back('{addr: addr, data: ref_mem[addr] | mask});
        ref_mem[addr] = ref_mem[addr] | mask;
        px_we     = 1'b1;
        px_wrdata = px_rddata | mask;
        if (fs) push_clear();
        step();
        px_we  = 1'b0;
        px_req = 1'b0;
        check("gnt held while req drops", 64'(px_gnt), 1);
        step();
        check("gnt released", 64'(px_gnt), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {px_gnt, mem_we, mem_rdaddr, mem_wraddr, clear_busy, clear_done,
                     clear_overrun}, 0);
        check({name, " wrdata"}, 64'(mem_wrdata), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        resetn      = 1'b0;
        frame_start = 1'b0;
        px_req      = 1'b0;
        px_addr     = '0;
        px_we       = 1'b0;
        px_wrdata   = '0;
        repeat (3) step();
        resetn = 1'b1;

        // Idle after reset: all outputs stay low.
        for (int i = 0; i < 20; i++) begin
            step();
            check_outputs_zero("idle after reset");
        end

        rmw(14'h0123, 32'h8000_0000, 1'b0);

        start_clear();
        wait_done();
        for (int a = 0; a < NW; a++) rmw(AW'(a), '0, 1'b0);

        // Frame start during an RMW: clear waits, re-requesting writer waits for the clear.
        rmw(14'h0040, 32'h0000_00F0, 1'b1);
        rmw(14'h0041, 32'h0F00_0000, 1'b0);
        check("no overrun yet", 64'(clear_overrun), 0);

        start_clear();
        repeat (10) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("overrun set", 64'(clear_overrun), 1);
        wait_done();
        repeat (30) step();
        check("overrun sticky", 64'(clear_overrun), 1);

        // Reset during clear cycle 7; words 7..15 already hold zero in both models.
        start_clear();
        repeat (7) step();
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check_outputs_zero("outputs during reset");
        repeat (3) step();
        resetn = 1'b1;
        step();
        check_outputs_zero("idle after mid-clear reset");
        rmw(14'h0005, 32'h0000_0101, 1'b0);
        repeat (40) step();

        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            bit            fs;
            a  = ($urandom_range(0, 5) == 0) ? 14'h0123 : AW'($urandom_range(0, 31));
            fs = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                start_clear();
                wait_done();
            end else begin
                rmw(a, $urandom & $urandom, fs);
                if (fs) wait_done();
            end
            repeat ($urandom_range(0, 3)) step();
        end

        for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
        repeat (5) step();
        check("expected writes outstanding", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
